// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Purpose  : Upstream feeder for the datapath shifter. Owns an NREGS x DATA_W
//            register file with one write port and one combinational read
//            port. Each accepted request reads operand A (rn) and operand B
//            (rm) on consecutive cycles, then presents A, B and the 2-bit
//            shift code on a valid/ready handshake.
// Ports    : clk, reset_n            - clock, async active-low reset
//            wr_en/wr_num/wr_data    - register-file write port
//            req_valid/req_ready     - request handshake (rn, rm, shift_in)
//            out_valid/out_ready     - operand handshake (a_out, b_out,
//                                      shift_out)
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [2:0]        wr_num,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        rn,
    input  logic [2:0]        rm,
    input  logic [1:0]        shift_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [1:0]        shift_out
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_READ_A = 2'd1;
    localparam logic [1:0] c_READ_B = 2'd2;
    localparam logic [1:0] c_HOLD   = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;

    logic [DATA_W-1:0] r_regs [NREGS];

    // Request fields captured at acceptance; later changes on rn/rm/shift_in
    // are deliberately ignored.
    logic [2:0]        r_rn;
    logic [2:0]        r_rm;
    logic [1:0]        r_shift_hold;

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [1:0]        r_shift;
    logic              r_out_valid;
    logic              r_req_ready;

    logic              w_accept;
    logic              w_latch_a;
    logic              w_latch_b;
    logic [2:0]        w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:   if (req_valid) w_next_state = c_READ_A;
            c_READ_A: w_next_state = c_READ_B;
            c_READ_B: w_next_state = c_HOLD;
            c_HOLD:   if (out_ready) w_next_state = c_IDLE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode (datapath controls)
    // ------------------------------------------------------------------
    always_comb begin
        w_accept  = 1'b0;
        w_latch_a = 1'b0;
        w_latch_b = 1'b0;
        w_rd_addr = r_rn;
        case (r_state)
            c_IDLE:   w_accept  = req_valid;
            c_READ_A: w_latch_a = 1'b1;
            c_READ_B: begin
                w_latch_b = 1'b1;
                w_rd_addr = r_rm;
            end
            default: ;
        endcase
    end

    // Single read port with write bypass: a same-cycle write to the address
    // being read is forwarded so the operand sees the new value.
    always_comb begin
        w_rd_data = r_regs[w_rd_addr];
        if (wr_en && (wr_num == w_rd_addr)) begin
            w_rd_data = wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Register file: writes are independent of the FSM state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en) begin
            r_regs[wr_num] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Request capture, operand latches and registered handshake flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rn         <= '0;
            r_rm         <= '0;
            r_shift_hold <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_shift      <= '0;
            r_out_valid  <= 1'b0;
            r_req_ready  <= 1'b1;
        end else begin
            if (w_accept) begin
                r_rn         <= rn;
                r_rm         <= rm;
                r_shift_hold <= shift_in;
            end
            if (w_latch_a) begin
                r_a <= w_rd_data;
            end
            if (w_latch_b) begin
                r_b     <= w_rd_data;
                r_shift <= r_shift_hold;
            end
            // Flags are registered from the next state so they track the
            // FSM exactly while staying glitch-free flop outputs.
            r_out_valid <= (w_next_state == c_HOLD);
            r_req_ready <= (w_next_state == c_IDLE);
        end
    end

    assign req_ready = r_req_ready;
    assign out_valid = r_out_valid;
    assign a_out     = r_a;
    assign b_out     = r_b;
    assign shift_out = r_shift;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch
// Purpose  : Directed self-checking bench for operand_fetch. Each scenario
//            task drives its own stimulus and compares outputs against
//            hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [2:0]  wr_num;
    logic [15:0] wr_data;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [1:0]  shift_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic [1:0]  shift_out;

    int checks   = 0;
    int failures = 0;

    operand_fetch #(
        .DATA_W (16),
        .NREGS  (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_num    (wr_num),
        .wr_data   (wr_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rn        (rn),
        .rm        (rm),
        .shift_in  (shift_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .shift_out (shift_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of the downstream shifter (shift by one bit).
    function automatic logic [15:0] shifter_model(input logic [15:0] b,
                                                  input logic [1:0]  s);
        case (s)
            2'b01:   return b << 1;
            2'b10:   return b >> 1;
            2'b11:   return 16'($signed(b) >>> 1);
            default: return b;
        endcase
    endfunction

    // Stimulus: one register-file write on the next rising edge.
    task automatic write_reg(input logic [2:0] n, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_num = n; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Stimulus: issue a request from IDLE and count edges (acceptance edge
    // included) until out_valid is seen; -1 means it never came.
    task automatic fetch(input logic [2:0] a, input logic [2:0] b,
                         input logic [1:0] s, output int edges);
        @(negedge clk);
        rn = a; rm = b; shift_in = s; req_valid = 1'b1;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            req_valid = 1'b0;
        end while (!out_valid && edges < 10);
        if (!out_valid) edges = -1;
    endtask

    task automatic test_reset;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (a_out !== 16'h0 || b_out !== 16'h0 || shift_out !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs got a=%h b=%h s=%b exp 0", a_out, b_out, shift_out);
        end
    endtask

    task automatic test_basic_fetch;
        int edges;
        write_reg(3'd3, 16'hF0F0);
        write_reg(3'd5, 16'h1234);
        out_ready = 1'b1;
        fetch(3'd5, 3'd3, 2'b01, edges);
        checks++;
        if (edges !== 3) begin
            failures++; $display("FAIL basic_latency got=%0d exp=3", edges);
        end
        checks++;
        if (a_out !== 16'h1234) begin
            failures++; $display("FAIL basic_a got=%h exp=1234", a_out);
        end
        checks++;
        if (b_out !== 16'hF0F0) begin
            failures++; $display("FAIL basic_b got=%h exp=f0f0", b_out);
        end
        checks++;
        if (shift_out !== 2'b01) begin
            failures++; $display("FAIL basic_shift got=%b exp=01", shift_out);
        end
        checks++;
        if (shifter_model(b_out, shift_out) !== 16'hE1E0) begin
            failures++;
            $display("FAIL basic_shifter got=%h exp=e1e0", shifter_model(b_out, shift_out));
        end
        checks++;
        if (req_ready !== 1'b0) begin
            failures++; $display("FAIL basic_ready_in_hold got=%b exp=0", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_release got valid=%b ready=%b exp valid=0 ready=1",
                     out_valid, req_ready);
        end
    endtask

    task automatic test_backpressure;
        int edges;
        out_ready = 1'b0;
        fetch(3'd5, 3'd3, 2'b01, edges);
        checks++;
        if (edges !== 3 || a_out !== 16'h1234 || b_out !== 16'hF0F0) begin
            failures++;
            $display("FAIL bp_fetch got edges=%0d a=%h b=%h exp 3/1234/f0f0", edges, a_out, b_out);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rn = ~rn; rm = ~rm; shift_in = ~shift_in; req_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || req_ready !== 1'b0 || a_out !== 16'h1234 ||
                b_out !== 16'hF0F0 || shift_out !== 2'b01) begin
                failures++;
                $display("FAIL bp_hold_%0d got v=%b r=%b a=%h b=%h s=%b exp 1/0/1234/f0f0/01",
                         i, out_valid, req_ready, a_out, b_out, shift_out);
            end
        end
        // Handshake edge: the pending request must not be taken at this edge.
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got valid=%b ready=%b exp 0/1", out_valid, req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL bp_no_accept got ready=%b exp=1", req_ready);
        end
    endtask

    task automatic test_bypass;
        int edges;
        write_reg(3'd2, 16'h0001);
        @(negedge clk);
        rn = 3'd2; rm = 3'd2; shift_in = 2'b10; req_valid = 1'b1;
        @(posedge clk); #1;                      // accepted, now READ_A
        req_valid = 1'b0;
        wr_en = 1'b1; wr_num = 3'd2; wr_data = 16'hAAAA;
        @(posedge clk); #1;                      // A latched, now READ_B
        wr_data = 16'h5555;
        @(posedge clk); #1;                      // B latched, now HOLD
        wr_en = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL bypass_valid got=%b exp=1", out_valid);
        end
        checks++;
        if (a_out !== 16'hAAAA) begin
            failures++; $display("FAIL bypass_a got=%h exp=aaaa", a_out);
        end
        checks++;
        if (b_out !== 16'h5555) begin
            failures++; $display("FAIL bypass_b got=%h exp=5555", b_out);
        end
        @(posedge clk); #1;                      // consumed (out_ready=1)
        fetch(3'd2, 3'd0, 2'b00, edges);
        checks++;
        if (edges !== 3 || a_out !== 16'h5555 || b_out !== 16'h0000) begin
            failures++;
            $display("FAIL bypass_readback got edges=%0d a=%h b=%h exp 3/5555/0000",
                     edges, a_out, b_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int edges;
        @(negedge clk);
        rn = 3'd5; rm = 3'd3; shift_in = 2'b10; req_valid = 1'b1;
        @(posedge clk); #1;                      // READ_A
        req_valid = 1'b0;
        @(posedge clk); #1;                      // READ_B, a_out = 1234
        checks++;
        if (a_out !== 16'h1234) begin
            failures++; $display("FAIL mid_pre_a got=%h exp=1234", a_out);
        end
        #2 reset_n = 1'b0;                       // mid-cycle, no clock edge
        #1;
        checks++;
        if (a_out !== 16'h0 || b_out !== 16'h0 || shift_out !== 2'b00 ||
            out_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_async got a=%h b=%h s=%b v=%b r=%b exp 0/0/00/0/1",
                     a_out, b_out, shift_out, out_valid, req_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
                failures++;
                $display("FAIL mid_no_replay_%0d got v=%b r=%b exp 0/1", i, out_valid, req_ready);
            end
        end
        fetch(3'd0, 3'd7, 2'b11, edges);
        checks++;
        if (edges !== 3 || a_out !== 16'h0 || b_out !== 16'h0 || shift_out !== 2'b11) begin
            failures++;
            $display("FAIL mid_refetch got edges=%0d a=%h b=%h s=%b exp 3/0000/0000/11",
                     edges, a_out, b_out, shift_out);
        end
        @(posedge clk); #1;
        fetch(3'd5, 3'd3, 2'b01, edges);
        checks++;
        if (a_out !== 16'h0 || b_out !== 16'h0) begin
            failures++;
            $display("FAIL mid_regs_cleared got a=%h b=%h exp 0000/0000", a_out, b_out);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        wr_en     = 1'b0;
        wr_num    = '0;
        wr_data   = '0;
        req_valid = 1'b0;
        rn        = '0;
        rm        = '0;
        shift_in  = '0;
        out_ready = 1'b1;
        #12 reset_n = 1'b1;

        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_bypass();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
